// File: rtl/dmem_chk_pkg.sv
// Shared types and helpers for the data-memory read-back checker.
package dmem_chk_pkg;

    localparam int WORD_W         = 32;
    localparam int DEFAULT_NWORDS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width for n words; never below one bit so a one-word check still has an index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_checker_if.sv
// Read port onto dmem plus the expected-value ROM port, both combinational on the memory side.
interface dmem_checker_if
    import dmem_chk_pkg::*;
#(
    parameter  int NWORDS = DEFAULT_NWORDS,
    localparam int IW     = idx_width(NWORDS)
);
    logic              rd_en;
    logic [WORD_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [IW-1:0]     exp_addr;
    logic [WORD_W-1:0] exp_data;

    // Checker side: drives addresses, consumes data.
    modport master (
        output rd_en,
        output rd_addr,
        output exp_addr,
        input  rd_data,
        input  exp_data
    );

    // Memory / ROM side: returns data for the presented addresses.
    modport slave (
        input  rd_en,
        input  rd_addr,
        input  exp_addr,
        output rd_data,
        output exp_data
    );
endinterface

// File: rtl/dmem_chk_stage.sv
// Capture stage: registers one dmem word and its expected value, then flags a difference.
module dmem_chk_stage
    import dmem_chk_pkg::*;
#(
    parameter int IW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [IW-1:0]     in_idx,
    input  logic [WORD_W-1:0] in_got,
    input  logic [WORD_W-1:0] in_exp,
    output logic              cmp_v,
    output logic [IW-1:0]     cmp_idx,
    output logic [WORD_W-1:0] got_q,
    output logic [WORD_W-1:0] exp_q,
    output logic              mismatch
);

    logic              cmp_v_reg;
    logic [IW-1:0]     cmp_idx_reg;
    logic [WORD_W-1:0] got_reg;
    logic [WORD_W-1:0] exp_reg;
    logic [WORD_W-1:0] diff;

    // Capture the word under test on every scan cycle; valid drops as soon as scanning stops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp_v_reg   <= 1'b0;
            cmp_idx_reg <= '0;
            got_reg     <= '0;
            exp_reg     <= '0;
        end else begin
            cmp_v_reg <= capture;
            if (capture) begin
                cmp_idx_reg <= in_idx;
                got_reg     <= in_got;
                exp_reg     <= in_exp;
            end
        end
    end

    // Full-width bitwise difference, no masking.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_diff
            assign diff[gi] = got_reg[gi] ^ exp_reg[gi];
        end
    endgenerate

    assign cmp_v    = cmp_v_reg;
    assign cmp_idx  = cmp_idx_reg;
    assign got_q    = got_reg;
    assign exp_q    = exp_reg;
    assign mismatch = cmp_v_reg && (|diff);

endmodule

// File: rtl/dmem_checker.sv
// Walks NWORDS dmem words against an expected ROM at one word per cycle and reports results.
module dmem_checker
    import dmem_chk_pkg::*;
#(
    parameter  int          NWORDS    = DEFAULT_NWORDS,
    parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int          IW        = idx_width(NWORDS),
    localparam int          CW        = $clog2(NWORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    dmem_checker_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CW-1:0]     fail_count,
    output logic              mm_valid,
    output logic [IW-1:0]     mm_idx,
    output logic [WORD_W-1:0] mm_got,
    output logic [WORD_W-1:0] mm_exp,
    output logic [IW-1:0]     first_idx,
    output logic [WORD_W-1:0] first_got,
    output logic [WORD_W-1:0] first_exp
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_t            state_reg, state_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [CW-1:0]     fail_reg, fail_next;
    logic [IW-1:0]     first_idx_reg, first_idx_next;
    logic [WORD_W-1:0] first_got_reg, first_got_next;
    logic [WORD_W-1:0] first_exp_reg, first_exp_next;

    logic              stg_cmp_v;
    logic [IW-1:0]     stg_idx;
    logic [WORD_W-1:0] stg_got;
    logic [WORD_W-1:0] stg_exp;
    logic              stg_mismatch;
    logic              scanning;

    assign scanning = (state_reg == SCAN);

    dmem_chk_stage #(
        .IW (IW)
    ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .capture  (scanning),
        .in_idx   (idx_reg),
        .in_got   (bus.rd_data),
        .in_exp   (bus.exp_data),
        .cmp_v    (stg_cmp_v),
        .cmp_idx  (stg_idx),
        .got_q    (stg_got),
        .exp_q    (stg_exp),
        .mismatch (stg_mismatch)
    );

    // State, scan index, failure count and first-failure record.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            fail_reg      <= '0;
            first_idx_reg <= '0;
            first_got_reg <= '0;
            first_exp_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            fail_reg      <= fail_next;
            first_idx_reg <= first_idx_next;
            first_got_reg <= first_got_next;
            first_exp_reg <= first_exp_next;
        end
    end

    // Next-state logic; a start in IDLE/DONE overrides everything and clears the previous results.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        fail_next      = fail_reg;
        first_idx_next = first_idx_reg;
        first_got_next = first_got_reg;
        first_exp_next = first_exp_reg;

        // The stage only holds a valid word during SCAN/DRAIN, so this never fires in IDLE/DONE.
        if (stg_mismatch) begin
            fail_next = fail_reg + CW'(1);
            if (fail_reg == '0) begin
                first_idx_next = stg_idx;
                first_got_next = stg_got;
                first_exp_next = stg_exp;
            end
        end

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = SCAN;
                    idx_next       = '0;
                    fail_next      = '0;
                    first_idx_next = '0;
                    first_got_next = '0;
                    first_exp_next = '0;
                end
            end
            SCAN: begin
                // Index parks on the last word rather than wrapping.
                if (idx_reg == LAST_IDX) begin
                    state_next = DRAIN;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rd_en    = scanning;
    assign bus.rd_addr  = BASE_ADDR + (32'(idx_reg) << 2);
    assign bus.exp_addr = idx_reg;

    assign busy       = (state_reg == SCAN) || (state_reg == DRAIN);
    assign done       = (state_reg == DONE);
    assign pass       = done && (fail_reg == '0);
    assign fail_count = fail_reg;

    assign mm_valid = stg_mismatch;
    assign mm_idx   = stg_idx;
    assign mm_got   = stg_got;
    assign mm_exp   = stg_exp;

    assign first_idx = first_idx_reg;
    assign first_got = first_got_reg;
    assign first_exp = first_exp_reg;

endmodule

// File: tb/tb_dmem_checker.sv
// Directed bench for dmem_checker: a 32-word instance at base 0 and a 4-word instance at 0x80.
module tb_dmem_checker;

    logic clk;
    logic reset_a, start_a, reset_b, start_b;

    logic        busy_a, done_a, pass_a, mm_valid_a;
    logic [5:0]  fail_count_a;
    logic [4:0]  mm_idx_a, first_idx_a;
    logic [31:0] mm_got_a, mm_exp_a, first_got_a, first_exp_a;

    logic        busy_b, done_b, pass_b, mm_valid_b;
    logic [2:0]  fail_count_b;
    logic [1:0]  mm_idx_b, first_idx_b;
    logic [31:0] mm_got_b, mm_exp_b, first_got_b, first_exp_b;

    logic [31:0] dmem   [32];
    logic [31:0] expv   [32];
    logic [31:0] dmem_b [4];
    logic [31:0] expv_b [4];
    logic [31:0] off_b;

    int n_checks = 0;
    int n_fail   = 0;
    int mm_cyc[$];
    int mm_ix[$];
    logic [31:0] mm_g[$];
    logic [31:0] mm_e[$];

    dmem_checker_if #(.NWORDS(32)) bus_a ();
    dmem_checker_if #(.NWORDS(4))  bus_b ();

    dmem_checker #(.NWORDS(32), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .bus(bus_a.master),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fail_count_a),
        .mm_valid(mm_valid_a), .mm_idx(mm_idx_a), .mm_got(mm_got_a), .mm_exp(mm_exp_a),
        .first_idx(first_idx_a), .first_got(first_got_a), .first_exp(first_exp_a)
    );

    dmem_checker #(.NWORDS(4), .BASE_ADDR(32'h0000_0080)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .bus(bus_b.master),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fail_count_b),
        .mm_valid(mm_valid_b), .mm_idx(mm_idx_b), .mm_got(mm_got_b), .mm_exp(mm_exp_b),
        .first_idx(first_idx_b), .first_got(first_got_b), .first_exp(first_exp_b)
    );

    // Combinational memory and ROM models.
    always_comb begin
        bus_a.rd_data  = dmem[bus_a.rd_addr[6:2]];
        bus_a.exp_data = expv[bus_a.exp_addr];
        off_b          = bus_b.rd_addr - 32'h0000_0080;
        bus_b.rd_data  = dmem_b[off_b[3:2]];
        bus_b.exp_data = expv_b[bus_b.exp_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 32; i++) begin
            dmem[i] = 32'(i * 3);
            expv[i] = 32'(i * 3);
        end
    endtask

    task automatic set_three_mismatches();
        init_mem();
        dmem[0]  = 32'hDEAD_0000;   // expected 0x00
        dmem[17] = 32'h8000_0033;   // expected 0x33, differs only in bit 31
        dmem[31] = 32'h0000_005C;   // expected 0x5D, differs only in bit 0
    endtask

    // Full 32-word run on DUT A: pulses start, tracks addresses and mismatch pulses up to E33.
    task automatic scan_a();
        mm_cyc.delete(); mm_ix.delete(); mm_g.delete(); mm_e.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            if (k < 32) begin
                check($sformatf("rd_addr k=%0d", k), bus_a.rd_addr, 32'(4 * k));
                check($sformatf("exp_addr k=%0d", k), 32'(bus_a.exp_addr), 32'(k));
            end
            if (k == 0) begin
                check("busy@E0", 32'(busy_a), 32'd1);
                check("rd_en@E0", 32'(bus_a.rd_en), 32'd1);
            end
            if (mm_valid_a) begin
                mm_cyc.push_back(k);
                mm_ix.push_back(int'(mm_idx_a));
                mm_g.push_back(mm_got_a);
                mm_e.push_back(mm_exp_a);
            end
            if (k == 32) check("done@E32", 32'(done_a), 32'd0);
            if (k == 33) begin
                check("done@E33", 32'(done_a), 32'd1);
                check("busy@E33", 32'(busy_a), 32'd0);
                check("rd_en@E33", 32'(bus_a.rd_en), 32'd0);
            end
            if (k < 33) tick();
        end
        $display("run: fail_count=%0d pass=%0d mm_pulses=%0d", fail_count_a, pass_a, mm_cyc.size());
    endtask

    task automatic expect_mm(input int i, input int cyc, input int ix, input logic [31:0] g, input logic [31:0] e);
        if (mm_cyc.size() > i) begin
            check($sformatf("mm%0d cycle", i), 32'(mm_cyc[i]), 32'(cyc));
            check($sformatf("mm%0d idx", i), 32'(mm_ix[i]), 32'(ix));
            check($sformatf("mm%0d got", i), mm_g[i], g);
            check($sformatf("mm%0d exp", i), mm_e[i], e);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " busy"}, 32'(busy_a), 32'd0);
        check({tag, " done"}, 32'(done_a), 32'd0);
        check({tag, " pass"}, 32'(pass_a), 32'd0);
        check({tag, " rd_en"}, 32'(bus_a.rd_en), 32'd0);
        check({tag, " fail_count"}, 32'(fail_count_a), 32'd0);
        check({tag, " mm_valid"}, 32'(mm_valid_a), 32'd0);
        check({tag, " first_idx"}, 32'(first_idx_a), 32'd0);
        check({tag, " first_got"}, first_got_a, 32'd0);
        check({tag, " first_exp"}, first_exp_a, 32'd0);
        check({tag, " rd_addr"}, bus_a.rd_addr, 32'd0);
        check({tag, " exp_addr"}, 32'(bus_a.exp_addr), 32'd0);
    endtask

    initial begin
        reset_a = 1'b0; reset_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        init_mem();
        for (int i = 0; i < 4; i++) begin
            dmem_b[i] = 32'(i + 100);
            expv_b[i] = 32'(i + 100);
        end
        tick(); tick();
        check_reset_a("reset");
        check("reset b rd_addr", bus_b.rd_addr, 32'h0000_0080);
        reset_a = 1'b1; reset_b = 1'b1;
        tick();

        // 1: every word matches.
        scan_a();
        check("t1 pass", 32'(pass_a), 32'd1);
        check("t1 fail_count", 32'(fail_count_a), 32'd0);
        check("t1 mm pulses", 32'(mm_cyc.size()), 32'd0);

        // 2: single mismatch at word 5.
        dmem[5] = 32'h0000_0010;
        expv[5] = 32'h0000_0011;
        scan_a();
        check("t2 mm pulses", 32'(mm_cyc.size()), 32'd1);
        expect_mm(0, 6, 5, 32'h10, 32'h11);
        check("t2 fail_count", 32'(fail_count_a), 32'd1);
        check("t2 first_idx", 32'(first_idx_a), 32'd5);
        check("t2 first_got", first_got_a, 32'h10);
        check("t2 first_exp", first_exp_a, 32'h11);
        check("t2 pass", 32'(pass_a), 32'd0);

        // 3: mismatches at words 0, 17 and 31.
        set_three_mismatches();
        scan_a();
        check("t3 mm pulses", 32'(mm_cyc.size()), 32'd3);
        expect_mm(0, 1, 0, 32'hDEAD_0000, 32'h0);
        expect_mm(1, 18, 17, 32'h8000_0033, 32'h33);
        expect_mm(2, 32, 31, 32'h5C, 32'h5D);
        check("t3 fail_count", 32'(fail_count_a), 32'd3);
        check("t3 first_idx", 32'(first_idx_a), 32'd0);
        check("t3 first_got", first_got_a, 32'hDEAD_0000);
        check("t3 first_exp", first_exp_a, 32'h0);
        check("t3 pass", 32'(pass_a), 32'd0);

        // 4: reset during the scan aborts; the rerun counts from zero.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        check("t4 fail before reset", 32'(fail_count_a), 32'd1);
        reset_a = 1'b0;
        tick();
        check_reset_a("t4 midscan reset");
        reset_a = 1'b1;
        tick();
        scan_a();
        check("t4 rerun fail_count", 32'(fail_count_a), 32'd3);
        check("t4 rerun first_idx", 32'(first_idx_a), 32'd0);

        // 5: start pulse mid-scan is ignored; start held through DONE restarts.
        start_a = 1'b1;
        tick();                                 // E0
        start_a = 1'b0;
        for (int k = 1; k <= 5; k++) tick();   // after E5
        start_a = 1'b1;
        tick();                                 // E6 samples start in SCAN
        start_a = 1'b0;
        check("t5 ignored start rd_addr", bus_a.rd_addr, 32'd24);
        check("t5 ignored start busy", 32'(busy_a), 32'd1);
        for (int k = 7; k <= 31; k++) tick();  // after E31
        start_a = 1'b1;
        tick();                                 // E32
        check("t5 done@E32", 32'(done_a), 32'd0);
        tick();                                 // E33
        check("t5 done@E33", 32'(done_a), 32'd1);
        check("t5 fail_count@E33", 32'(fail_count_a), 32'd3);
        tick();                                 // E34 restarts
        start_a = 1'b0;
        check("t5 restart done", 32'(done_a), 32'd0);
        check("t5 restart busy", 32'(busy_a), 32'd1);
        check("t5 restart fail_count", 32'(fail_count_a), 32'd0);
        check("t5 restart first_got", first_got_a, 32'd0);
        check("t5 restart rd_addr", bus_a.rd_addr, 32'd0);
        for (int k = 1; k <= 33; k++) tick();
        check("t5 second done", 32'(done_a), 32'd1);
        check("t5 second fail_count", 32'(fail_count_a), 32'd3);
        $display("run: restart sequence fail_count=%0d", fail_count_a);

        // 6: four words at base 0x80.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b rd_addr k=%0d", k), bus_b.rd_addr, 32'h80 + 32'(4 * k));
            check($sformatf("b exp_addr k=%0d", k), 32'(bus_b.exp_addr), 32'(k));
            tick();
        end
        check("b done@E4", 32'(done_b), 32'd0);
        check("b busy@E4", 32'(busy_b), 32'd1);
        tick();
        check("b done@E5", 32'(done_b), 32'd1);
        check("b pass", 32'(pass_b), 32'd1);
        check("b fail_count", 32'(fail_count_b), 32'd0);
        $display("run: small instance done=%0d pass=%0d", done_b, pass_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_checker.md
# dmem_checker

Hardware read-back checker for the single-cycle CPU data memory. After a program run, the checker walks the first NWORDS words of dmem through a dedicated read port, compares each against an expected-value ROM, and reports pass/fail, mismatch count and first-failure details. It is the reading counterpart to the CPU's data-write path and replaces the simulation-only dump loop with synthesizable, self-checking logic.

## Interface

Parameters:
- NWORDS, 32, number of consecutive words checked
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge)
- start  in  1  begin a check; honoured only in IDLE or DONE
- rd_en  out  1  high while the checker owns the dmem read port (SCAN only)
- rd_addr  out  32  dmem byte address = BASE_ADDR + 4*idx
- rd_data  in  32  combinational dmem read data for rd_addr, same cycle
- exp_addr  out  $clog2(NWORDS)  expected-ROM index = idx
- exp_data  in  32  combinational expected word for exp_addr
- busy  out  1  check in progress
- done  out  1  results valid, held until next start or reset
- pass  out  1  done && fail_count==0
- fail_count  out  $clog2(NWORDS+1)  mismatches in current/last run
- mm_valid  out  1  one-cycle flag per mismatching word
- mm_idx  out  $clog2(NWORDS)  index of mismatching word
- mm_got, mm_exp  out  32 each  dmem value / expected value of that word
- first_idx  out  $clog2(NWORDS)  index of first mismatch in run
- first_got, first_exp  out  32 each  values of first mismatch

## Operation

- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE/DONE + start=1: idx<=0, fail_count<=0, first_* <=0, done<=0, state<=SCAN.
- SCAN: each cycle rd_addr/exp_addr present idx; capture stage registers got_q<=rd_data, exp_q<=exp_data, cmp_idx<=idx, cmp_v<=1; idx<=idx+1; on idx==NWORDS-1 state<=DRAIN (idx stops, no wrap).
- DRAIN: cmp_v<=0; state<=DONE.
- Compare stage (SCAN/DRAIN/DONE edge following a capture): if cmp_v && got_q!=exp_q: fail_count<=fail_count+1; if fail_count==0, first_idx/got/exp <= cmp_idx/got_q/exp_q.
- mm_valid = cmp_v && (got_q!=exp_q); mm_idx/got/exp = cmp_idx/got_q/exp_q; all register-derived, no input paths.
- Comparison is full 32-bit bitwise; no masking.
- fail_count cannot overflow (width holds NWORDS).
- start during SCAN/DRAIN ignored; start held high in DONE restarts every time DONE is reached.
- rd_en=1 only in SCAN; rd_addr/exp_addr still driven (from idx) outside SCAN.

## Timing

- Reset (reset==0 at edge): state IDLE, idx 0, busy 0, done 0, pass 0, rd_en 0, fail_count 0, cmp_v 0, mm_valid 0, first_* 0, rd_addr=BASE_ADDR, exp_addr 0. Reset mid-SCAN aborts immediately; no partial results retained.
- Edge E0 samples start: busy=1 and rd_en=1 from E0 onward.
- Word k addressed in cycle between E(k) and E(k+1); captured at E(k+1), k=0..NWORDS-1.
- mm_valid for word k visible between E(k+1) and E(k+2).
- done=1, busy=0 after E(NWORDS+1): 33 cycles after start edge for NWORDS=32.
- Throughput one word/cycle; no stalls.

## Structure

- Package dmem_chk_pkg: state enum (IDLE, SCAN, DRAIN, DONE), default NWORDS, word width 32, index-width function.
- One sub-module: dmem_chk_stage (capture registers + comparator, outputs mismatch flag and data); FSM, counters and first-fail capture stay in dmem_checker.

## Test plan

- All 32 words equal (dmem[i]=exp[i]=i*3) -> done at E33, pass=1, fail_count=0, mm_valid never high.
- Word 5 dmem=32'h0000_0010, exp=32'h0000_0011 -> single mm_valid after E6 with mm_idx=5; fail_count=1, first_idx=5, first_got=0x10, first_exp=0x11, pass=0.
- Mismatches at words 0, 31 and 17 -> fail_count=3, first_idx=0; mm_valid pulses after E1, E18, E32.
- Reset low during cycle 10 of SCAN -> next edge all outputs at reset values; new start gives full 33-cycle run with fresh count.
- start pulsed during SCAN and held high through DONE -> mid-scan pulse ignored; run restarts one cycle after DONE, done drops, fail_count cleared.
- BASE_ADDR=32'h80, NWORDS=4 -> rd_addr sequence 0x80,0x84,0x88,0x8C; done after E5.
